// File: rtl/neuron_sequencer_pkg.sv
// Shared types and default sizing for the neuron dot-product sequencer.
// Sizes describe a 64x64x3 image with 8-bit unsigned pixels and 8-bit signed weights.
package neuron_sequencer_pkg;

  localparam int unsigned NUM_PIXELS_DEF   = 12288;
  localparam int unsigned ADDR_WIDTH_DEF   = 14;
  localparam int unsigned PIXEL_WIDTH_DEF  = 8;
  localparam int unsigned WEIGHT_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Zero-extended pixel (one extra bit) times signed weight.
  function automatic int unsigned prod_width(input int unsigned pix_w, input int unsigned wgt_w);
    return pix_w + wgt_w + 1;
  endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Shared pixel/weight memory port: address request/grant with read data one cycle after acceptance.
interface neuron_sequencer_if
  import neuron_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) ();

  logic                           mem_req;
  logic                           mem_gnt;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [PIXEL_WIDTH-1:0]         pixel_data;
  logic signed [WEIGHT_WIDTH-1:0] weight_data;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, pixel_data, weight_data
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, pixel_data, weight_data
  );

endinterface

// File: rtl/neuron_sequencer_mac.sv
// Signed pixel-by-weight multiplier feeding a clearable accumulator register.
module neuron_sequencer_mac
  import neuron_sequencer_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           en,
  input  logic [PIXEL_WIDTH-1:0]         pixel,
  input  logic signed [WEIGHT_WIDTH-1:0] weight,
  output logic signed [ACC_WIDTH-1:0]    acc
);

  localparam int unsigned PROD_WIDTH = prod_width(PIXEL_WIDTH, WEIGHT_WIDTH);

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;

  // Pixel is zero-extended so the multiply stays signed without misreading bit 7.
  always_comb begin
    prod  = PROD_WIDTH'($signed({1'b0, pixel})) * PROD_WIDTH'(weight);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_sequencer.sv
// Walks every pixel/weight pair through the shared memory port, accumulates the
// products, adds the bias and publishes a thresholded cat / not-cat score.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PIXELS   = NUM_PIXELS_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] bias,
  neuron_sequencer_if.master          mem,
  output logic                        busy,
  output logic                        done,
  output logic signed [ACC_WIDTH-1:0] score,
  output logic                        is_cat
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       index_q, index_d;
  logic                        v_d1_q, v_d1_d;
  logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
  logic signed [ACC_WIDTH-1:0] score_q, score_d;
  logic                        is_cat_q, is_cat_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        req_q, req_d;
  logic                        acc_clear;
  logic                        accept;
  logic signed [ACC_WIDTH-1:0] acc;

  assign accept = req_q & mem.mem_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (accept && (index_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request/busy are registered copies of the next state, so they track state_q exactly.
  always_comb begin
    index_d   = index_q;
    v_d1_d    = 1'b0;
    bias_d    = bias_q;
    score_d   = score_q;
    is_cat_d  = is_cat_q;
    done_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    req_d     = (state_d == ST_RUN);
    acc_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          index_d   = '0;
          bias_d    = bias;
          acc_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          index_d = index_q + ADDR_WIDTH'(1);
          v_d1_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        score_d  = acc + bias_q;
        is_cat_d = ~score_d[ACC_WIDTH-1] && (score_d != '0);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q  <= '0;
      v_d1_q   <= 1'b0;
      bias_q   <= '0;
      score_q  <= '0;
      is_cat_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      index_q  <= index_d;
      v_d1_q   <= v_d1_d;
      bias_q   <= bias_d;
      score_q  <= score_d;
      is_cat_q <= is_cat_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
    end
  end

  neuron_sequencer_mac #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .en     (v_d1_q),
    .pixel  (mem.pixel_data),
    .weight (mem.weight_data),
    .acc    (acc)
  );

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = index_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign score        = score_q;
  assign is_cat       = is_cat_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer with a sum-of-products reference model
// and a grant-counting latency model; small image of 4 pixels.
module tb_neuron_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 3;
  localparam int unsigned PW   = 8;
  localparam int unsigned WW   = 8;
  localparam int unsigned ACCW = 32;
  localparam int unsigned MEMD = 2 ** AW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic signed [ACCW-1:0] bias;
  logic                   busy;
  logic                   done;
  logic signed [ACCW-1:0] score;
  logic                   is_cat;

  logic [PW-1:0]        pix [MEMD];
  logic signed [WW-1:0] wgt [MEMD];
  logic [AW-1:0]        addr_log[$];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  neuron_sequencer_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW)) mem_if ();

  neuron_sequencer #(
    .NUM_PIXELS   (N),
    .ADDR_WIDTH   (AW),
    .PIXEL_WIDTH  (PW),
    .WEIGHT_WIDTH (WW),
    .ACC_WIDTH    (ACCW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bias   (bias),
    .mem    (mem_if),
    .busy   (busy),
    .done   (done),
    .score  (score),
    .is_cat (is_cat)
  );

  // Memory model: data for an accepted address appears the following cycle, garbage otherwise.
  always @(posedge clk) begin
    if (mem_if.mem_req === 1'b1 && mem_if.mem_gnt === 1'b1) begin
      addr_log.push_back(mem_if.mem_addr);
      mem_if.pixel_data  <= pix[mem_if.mem_addr];
      mem_if.weight_data <= wgt[mem_if.mem_addr];
    end else begin
      mem_if.pixel_data  <= PW'($urandom);
      mem_if.weight_data <= WW'($urandom);
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_score(input longint b);
    longint s = b;
    for (int i = 0; i < int'(N); i++) s += longint'(pix[i]) * longint'(wgt[i]);
    return s;
  endfunction

  function automatic logic pick_gnt(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called in the low clock phase; returns at the negedge of the done cycle.
  task automatic classify(input string tag, input logic signed [ACCW-1:0] b,
                          input int gmode, input int restart_at);
    int     k, highs, exp_edge, got_edge;
    logic   g;
    longint exp_s;
    addr_log.delete();
    exp_s  = ref_score(longint'(b));
    start  = 1'b1;
    bias   = b;
    mem_if.mem_gnt = 1'b0;
    @(posedge clk);
    k = 0; highs = 0; exp_edge = -1; got_edge = -1;
    while (k < 200) begin
      @(negedge clk);
      if (k > 0 && done === 1'b1) begin
        got_edge = k;
        break;
      end
      if (k == 1) check_eq({tag, " busy_in_run"}, longint'(busy), 1);
      start = (k == restart_at);
      g = pick_gnt(gmode, k);
      mem_if.mem_gnt = g;
      if (g && highs < int'(N)) begin
        highs++;
        if (highs == int'(N)) exp_edge = k + 3;
      end
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    mem_if.mem_gnt = 1'b0;
    check_eq({tag, " latency"}, longint'(got_edge), longint'(exp_edge));
    check_eq({tag, " score"}, longint'(score), exp_s);
    check_eq({tag, " is_cat"}, longint'(is_cat), longint'(exp_s > 0));
    check_eq({tag, " n_addr"}, longint'(addr_log.size()), longint'(N));
    for (int i = 0; i < addr_log.size() && i < int'(N); i++)
      check_eq($sformatf("%s addr%0d", tag, i), longint'(addr_log[i]), longint'(i));
  endtask

  task automatic idle_check(input string tag, input int n);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, " done_clear"}, longint'(done), 0);
    check_eq({tag, " busy_clear"}, longint'(busy), 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_plan_data();
    logic [PW-1:0]        p [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic signed [WW-1:0] w [4] = '{8'sd1, -8'sd2, 8'sd3, -8'sd4};
    for (int i = 0; i < 4; i++) begin
      pix[i] = p[i];
      wgt[i] = w[i];
    end
  endtask

  initial begin
    int   found;
    int   braw;
    rst = 1'b1; start = 1'b0; bias = '0; mem_if.mem_gnt = 1'b0;
    for (int i = 0; i < int'(MEMD); i++) begin
      pix[i] = '0;
      wgt[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset busy", longint'(busy), 0);
    check_eq("reset done", longint'(done), 0);
    check_eq("reset score", longint'(score), 0);
    check_eq("reset is_cat", longint'(is_cat), 0);
    check_eq("reset mem_req", longint'(mem_if.mem_req), 0);
    check_eq("reset mem_addr", longint'(mem_if.mem_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    load_plan_data();
    classify("plan_b50", 32'sd50, 0, -1);
    check_eq("plan_b50 const", longint'(score), -50);
    idle_check("plan_b50", 1);
    classify("plan_b150", 32'sd150, 0, -1);
    check_eq("plan_b150 const", longint'(score), 50);
    check_eq("plan_b150 cat", longint'(is_cat), 1);
    idle_check("plan_b150", 1);
    classify("plan_b100", 32'sd100, 0, -1);
    check_eq("plan_b100 const", longint'(score), 0);
    check_eq("plan_b100 cat", longint'(is_cat), 0);
    idle_check("plan_b100", 1);

    for (int i = 0; i < int'(N); i++) begin
      pix[i] = 8'd255;
      wgt[i] = -8'sd128;
    end
    classify("extreme", 32'sd0, 0, -1);
    check_eq("extreme const", longint'(score), -130560);
    idle_check("extreme", 1);

    load_plan_data();
    classify("toggle", 32'sd50, 1, -1);
    check_eq("toggle const", longint'(score), -50);
    idle_check("toggle", 1);

    // Abort a run part-way through with reset.
    start = 1'b1; bias = 32'sd50; mem_if.mem_gnt = 1'b1;
    @(posedge clk);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_if.mem_req === 1'b1 && mem_if.mem_addr == AW'(2)) begin
        found = 1;
        break;
      end
      @(posedge clk);
    end
    check_eq("midrst reached_addr2", longint'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst busy", longint'(busy), 0);
    check_eq("midrst done", longint'(done), 0);
    check_eq("midrst score", longint'(score), 0);
    check_eq("midrst is_cat", longint'(is_cat), 0);
    check_eq("midrst mem_req", longint'(mem_if.mem_req), 0);
    check_eq("midrst mem_addr", longint'(mem_if.mem_addr), 0);
    rst = 1'b0;
    mem_if.mem_gnt = 1'b0;
    @(negedge clk);
    classify("after_rst", 32'sd50, 0, -1);
    check_eq("after_rst const", longint'(score), -50);
    idle_check("after_rst", 1);

    // Start during RUN is dropped; start in the done cycle is taken.
    classify("restart", 32'sd150, 0, 2);
    classify("b2b", 32'sd50, 0, -1);
    check_eq("b2b const", longint'(score), -50);
    idle_check("b2b", 1);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        pix[i] = PW'($urandom);
        wgt[i] = WW'($urandom);
      end
      braw = int'($urandom_range(0, 200000)) - 100000;
      classify($sformatf("rnd%0d", t), ACCW'(braw), (t % 3 == 0) ? 0 : 2, (t % 4 == 1) ? 3 : -1);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", t), 0);
    end
    idle_check("final", 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
